apb_regbank_slave: RTL and testbench
====================================

// Module: apb_regbank_slave
// PURPOSE
// - Parametrised APB4 completer: bank of NUM_REGS DATA_W-bit registers behind APB, with programmable wait
//   states, byte strobes (pstrb), PSLVERR and read-only hardware-status registers.
// - Successor to the basic zero-wait APB slave. Sits at the APB side of the ICB-to-APB bridge as the
//   default target in block and system benches, and as a real CSR bank in the design.
// PARAMETERS
// - ADDR_W       32      paddr width
// - DATA_W       32      data width; multiple of 8, >=16
// - NUM_REGS     8       register count, >=1
// - BASE_ADDR    'h1000  byte address of register 0; must be aligned to DATA_W/8
// - WAIT_CYCLES  0       pready-low cycles in access phase (0..15)
// - RO_MASK      '0      NUM_REGS bits; bit i=1 -> reg i read-only, value from hw_in
// - RESET_VAL    '0      reset value of every RW register
// PORTS
// - clk           in   1                 clock, rising edge
// - rst           in   1                 synchronous, active-high reset
// - psel          in   1                 APB select
// - penable       in   1                 APB access phase
// - pwrite        in   1                 1=write 0=read
// - paddr         in   ADDR_W            byte address
// - pwdata        in   DATA_W            write data
// - pstrb         in   DATA_W/8          write byte strobes
// - prdata        out  DATA_W            read data, valid only with pready=1
// - pready        out  1                 transfer-complete strobe
// - pslverr       out  1                 error response, valid only with pready=1
// - reg_q         out  NUM_REGS*DATA_W   current register contents, reg i at [i*DATA_W +: DATA_W]
// - reg_wr_pulse  out  NUM_REGS          1-cycle pulse, the cycle after a successful write to reg i
// - hw_in         in   NUM_REGS*DATA_W   status values returned for RO registers
// BEHAVIOUR
// - Reset, checked at the clock edge:
//   - state=IDLE; pready, pslverr, reg_wr_pulse, prdata = 0.
//   - RW regs = RESET_VAL; reg_q of RO lanes = 0.
//   - Reset mid-transfer aborts it: no write commits, no pready is issued.
// - All outputs are registered. No combinational path from APB inputs to outputs.
// - FSM IDLE -> WAIT -> RESP -> IDLE. 4-bit down-counter cnt.
//   - IDLE: on psel & !penable (setup), latch paddr/pwrite/pwdata/pstrb. Load cnt=WAIT_CYCLES.
//     Go to RESP if WAIT_CYCLES==0, else go to WAIT.
//   - WAIT: with psel & penable, decrement cnt. When cnt reaches 1, go to RESP.
//   - RESP: pready=1 for exactly one cycle; prdata and pslverr valid. Next cycle pready=0, go to IDLE.
//   - Latency: pready is high in access cycle WAIT_CYCLES+1. WAIT_CYCLES=0 gives the APB minimum of
//     2 cycles per transfer.
//   - Back-to-back: a setup phase in the cycle after RESP is accepted normally.
//   - psel low in WAIT: abort to IDLE, no commit, no pready.
//   - penable high in IDLE without a prior setup (protocol violation): ignored, stay in IDLE.
// - Decode: off = latched paddr - BASE_ADDR; idx = off >> log2(DATA_W/8).
//   Error when any of the following holds:
//   - paddr < BASE_ADDR
//   - idx >= NUM_REGS
//   - low log2(DATA_W/8) address bits != 0
//   - write to an RO register
// - Error transfer: pslverr=1 with pready, prdata=0, no register change, no reg_wr_pulse.
// - Write OK: at the edge that raises pready, byte lane b of reg idx <= pwdata lane b where pstrb[b]=1.
//   reg_wr_pulse[idx] is high the cycle after pready. pstrb=0 -> OKAY response, no change, no pulse.
// - Read OK: prdata = reg idx, or hw_in lane idx if RO, sampled at the edge that raises pready.
//   pstrb is ignored on reads.
// - Latched pwdata/pstrb are used for the commit. Input changes during WAIT have no effect.
// STRUCTURE
// - Package apb_pkg: typedef enum logic[1:0] {APB_IDLE, APB_WAIT, APB_RESP} apb_state_e;
//   constants APB_OKAY=1'b0 and APB_SLVERR=1'b1; function apb_addr_idx() for decode and alignment.
// - Sub-module apb_slv_ctrl: FSM + wait counter + request latch. Outputs req_valid, req_idx, req_err
//   and the pready strobe. The top level holds the register array, strobe merge, read mux and pulses.
// TESTING (NUM_REGS=8, BASE_ADDR='h1000, RO_MASK=8'h80 unless noted)
// - After reset, read 'h1004 -> pready in 2nd cycle, prdata=0, pslverr=0.
// - Write 'h1008 data 'hDEADBEEF with pstrb=4'b0101, then read back -> 'h00AD00EF;
//   reg_wr_pulse[2] high 1 cycle.
// - WAIT_CYCLES=3: write then read -> pready low 3 access cycles, high on the 4th;
//   back-to-back transfers with no idle cycle between them.
// - Write 'h101C (RO, hw_in lane 7='h55) -> pslverr=1, no change;
//   read 'h101C -> 'h55; read 'h1020 and 'h1002 -> pslverr=1, prdata=0.
// - WAIT_CYCLES=3: drop psel in WAIT, and separately assert rst in WAIT -> no pready, reg unchanged;
//   next transfer completes normally.
// - Random APB4-compliant traffic vs. scoreboard model; assertion: pready high never 2 consecutive cycles.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB completer state type, response codes and address decode
package apb_pkg;
    typedef enum logic [1:0] {APB_IDLE, APB_WAIT, APB_RESP} apb_state_e;
    localparam logic APB_OKAY   = 1'b0;
    localparam logic APB_SLVERR = 1'b1;
    typedef struct packed {
        logic        err;
        logic [31:0] idx;
    } apb_dec_t;
    function automatic apb_dec_t apb_addr_idx(input logic [63:0] addr, input logic [63:0] base,
                                              input int unsigned lsb, input int unsigned num_regs);
        logic [63:0] off;
        apb_dec_t    d;
        off   = addr - base;
        d.idx = 32'(off >> lsb);
        d.err = (addr < base) || ((off >> lsb) >= 64'(num_regs)) ||
                ((off & ((64'd1 << lsb) - 64'd1)) != 64'd0);
        return d;
    endfunction
endpackage

// File: rtl/apb_slv_ctrl.sv
// apb_slv_ctrl: APB completer FSM, wait-state counter and request latch
module apb_slv_ctrl
    import apb_pkg::*;
#(
    parameter int                  ADDR_W      = 32,
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0]   BASE_ADDR   = 'h1000,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter int                  IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic                pready,
    output logic                req_valid,
    output logic                req_err,
    output logic                req_write,
    output logic [IDX_W-1:0]    req_idx,
    output logic [DATA_W-1:0]   req_wdata,
    output logic [DATA_W/8-1:0] req_strb
);
    localparam int LSB = $clog2(DATA_W / 8);
    apb_state_e          r_state, w_next;
    logic [3:0]          r_cnt, w_cnt;
    logic                r_pready, r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_strb;
    logic                w_setup, w_live;
    logic [ADDR_W-1:0]   w_addr;
    apb_dec_t            w_dec;
    assign w_setup = psel && !penable;
    assign w_live  = (r_state == APB_IDLE);
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        unique case (r_state)
            APB_IDLE: if (w_setup) begin
                w_cnt  = 4'(WAIT_CYCLES);
                w_next = (WAIT_CYCLES == 0) ? APB_RESP : APB_WAIT;
            end
            APB_WAIT: if (!psel) begin
                w_next = APB_IDLE;
            end else if (penable) begin
                w_cnt  = r_cnt - 4'd1;
                w_next = (r_cnt == 4'd1) ? APB_RESP : APB_WAIT;
            end
            default: w_next = APB_IDLE;
        endcase
    end
    // with zero wait states the commit edge is the setup edge, so the live bus is the request
    assign w_addr    = w_live ? paddr  : r_addr;
    assign req_write = w_live ? pwrite : r_write;
    assign req_wdata = w_live ? pwdata : r_wdata;
    assign req_strb  = w_live ? pstrb  : r_strb;
    assign w_dec     = apb_addr_idx(64'(w_addr), 64'(BASE_ADDR), LSB, NUM_REGS);
    assign req_idx   = IDX_W'(w_dec.idx);
    assign req_err   = w_dec.err || (req_write && RO_MASK[req_idx]);
    assign req_valid = (w_next == APB_RESP);
    assign pready    = r_pready;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= APB_IDLE;
            r_cnt    <= '0;
            r_pready <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt;
            r_pready <= req_valid;
        end
    end
    always_ff @(posedge clk) begin
        if (w_live && w_setup) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_strb  <= pstrb;
        end
    end
endmodule

// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB4 register bank with wait states, byte strobes, PSLVERR and RO status lanes
module apb_regbank_slave
    import apb_pkg::*;
#(
    parameter int                  ADDR_W      = 32,
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0]   BASE_ADDR   = 'h1000,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W/8-1:0]          pstrb,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          reg_wr_pulse,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_in
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_mask;
    logic                w_req_valid, w_req_err, w_req_write, w_commit;
    logic [IDX_W-1:0]    w_req_idx;
    logic [DATA_W-1:0]   w_req_wdata, w_rd;
    logic [NB-1:0]       w_req_strb;
    apb_slv_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR),
        .WAIT_CYCLES(WAIT_CYCLES), .RO_MASK(RO_MASK), .IDX_W(IDX_W)
    ) u_ctrl (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .req_valid(w_req_valid),
        .req_err(w_req_err), .req_write(w_req_write), .req_idx(w_req_idx),
        .req_wdata(w_req_wdata), .req_strb(w_req_strb)
    );
    assign w_commit = w_req_valid && w_req_write && !w_req_err;
    assign w_rd     = RO_MASK[w_req_idx] ? hw_in[w_req_idx*DATA_W +: DATA_W] : r_regs[w_req_idx];
    // the write pulse trails pready by one cycle, so it is staged through r_wr_mask
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RO_MASK[i] ? '0 : RESET_VAL;
            prdata       <= '0;
            pslverr      <= APB_OKAY;
            r_wr_mask    <= '0;
            reg_wr_pulse <= '0;
        end else begin
            prdata       <= (w_req_valid && !w_req_err && !w_req_write) ? w_rd : '0;
            pslverr      <= (w_req_valid && w_req_err) ? APB_SLVERR : APB_OKAY;
            r_wr_mask    <= '0;
            reg_wr_pulse <= r_wr_mask;
            if (w_commit && |w_req_strb) r_wr_mask[w_req_idx] <= 1'b1;
            for (int b = 0; b < NB; b++)
                if (w_commit && w_req_strb[b]) r_regs[w_req_idx][b*8 +: 8] <= w_req_wdata[b*8 +: 8];
        end
    end
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign reg_q[g*DATA_W +: DATA_W] = r_regs[g];
    end
endmodule

// File: tb/tb_apb_regbank_slave.sv
// tb_apb_regbank_slave: directed and random checks of the APB register bank at 0 and 3 wait states
module tb_apb_regbank_slave;
    logic         clk = 0, rst = 1;
    logic         psel0 = 0, psel3 = 0, penable = 0, pwrite = 0;
    logic [31:0]  paddr = '0, pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic [255:0] hw_in;
    logic [31:0]  prdata0, prdata3;
    logic         pready0, pready3, pslverr0, pslverr3;
    logic [255:0] reg_q0, reg_q3;
    logic [7:0]   pulse0, pulse3;
    int           checks = 0, errors = 0;
    logic [31:0]  rd;
    logic         er;
    int           lat;
    logic [31:0]  model [8];

    always #5 clk = ~clk;

    apb_regbank_slave #(.WAIT_CYCLES(0), .RO_MASK(8'h80)) dut0 (
        .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .reg_q(reg_q0), .reg_wr_pulse(pulse0), .hw_in(hw_in));
    apb_regbank_slave #(.WAIT_CYCLES(3), .RO_MASK(8'h80)) dut3 (
        .clk(clk), .rst(rst), .psel(psel3), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
        .reg_q(reg_q3), .reg_wr_pulse(pulse3), .hw_in(hw_in));

    a_pready0_single: assert property (@(posedge clk) disable iff (rst) !(pready0 && $past(pready0)));
    a_pready3_single: assert property (@(posedge clk) disable iff (rst) !(pready3 && $past(pready3)));

    task automatic apb_xfer(input logic sel3, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] r, output logic e, output int n);
        @(posedge clk); #1;
        psel0 = !sel3; psel3 = sel3; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1; n = 1;
        if (sel3) begin pwdata = ~d; pstrb = ~s; end
        while (!(sel3 ? pready3 : pready0) && n < 20) begin @(posedge clk); #1; n++; end
        r = sel3 ? prdata3 : prdata0;
        e = sel3 ? pslverr3 : pslverr0;
        checks++;
        if (!(sel3 ? pready3 : pready0)) begin errors++; $display("FAIL xfer_timeout addr=%h no pready after %0d cycles", a, n); end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel0 = 0; psel3 = 0; penable = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pready0 !== 0) begin errors++; $display("FAIL rst_pready got=%b exp=0", pready0); end
        checks++; if (pslverr0 !== 0) begin errors++; $display("FAIL rst_pslverr got=%b exp=0", pslverr0); end
        checks++; if (prdata0 !== 0) begin errors++; $display("FAIL rst_prdata got=%h exp=0", prdata0); end
        checks++; if (pulse0 !== 0) begin errors++; $display("FAIL rst_pulse got=%h exp=0", pulse0); end
        checks++; if (reg_q0 !== '0) begin errors++; $display("FAIL rst_reg_q got=%h exp=0", reg_q0); end
        checks++; if (pready3 !== 0) begin errors++; $display("FAIL rst_pready3 got=%b exp=0", pready3); end
        rst = 0;
        apb_xfer(0, 0, 32'h1004, 0, 0, rd, er, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rst_read_lat got=%0d exp=1", lat); end
        checks++; if (rd !== 0) begin errors++; $display("FAIL rst_read_data got=%h exp=0", rd); end
        checks++; if (er !== 0) begin errors++; $display("FAIL rst_read_err got=%b exp=0", er); end
    endtask

    task automatic test_write_strobe();
        apb_xfer(0, 1, 32'h1008, 32'hDEADBEEF, 4'b0101, rd, er, lat);
        checks++; if (er !== 0) begin errors++; $display("FAIL wr_err got=%b exp=0", er); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL wr_lat got=%0d exp=1", lat); end
        checks++; if (pulse0 !== 0) begin errors++; $display("FAIL wr_pulse_early got=%h exp=0", pulse0); end
        checks++; if (reg_q0[64 +: 32] !== 32'h00AD00EF) begin errors++; $display("FAIL wr_reg_q got=%h exp=00ad00ef", reg_q0[64 +: 32]); end
        idle();
        checks++; if (pulse0 !== 8'h04) begin errors++; $display("FAIL wr_pulse got=%h exp=04", pulse0); end
        @(posedge clk); #1;
        checks++; if (pulse0 !== 0) begin errors++; $display("FAIL wr_pulse_len got=%h exp=0", pulse0); end
        apb_xfer(0, 0, 32'h1008, 0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'h00AD00EF) begin errors++; $display("FAIL wr_readback got=%h exp=00ad00ef", rd); end
        apb_xfer(0, 1, 32'h1008, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        checks++; if (er !== 0) begin errors++; $display("FAIL nostrb_err got=%b exp=0", er); end
        idle();
        checks++; if (pulse0 !== 0) begin errors++; $display("FAIL nostrb_pulse got=%h exp=0", pulse0); end
        checks++; if (reg_q0[64 +: 32] !== 32'h00AD00EF) begin errors++; $display("FAIL nostrb_reg got=%h exp=00ad00ef", reg_q0[64 +: 32]); end
    endtask

    task automatic test_errors();
        apb_xfer(0, 1, 32'h101C, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        checks++; if (er !== 1) begin errors++; $display("FAIL ro_wr_err got=%b exp=1", er); end
        idle();
        checks++; if (pulse0 !== 0) begin errors++; $display("FAIL ro_wr_pulse got=%h exp=0", pulse0); end
        checks++; if (reg_q0[224 +: 32] !== 0) begin errors++; $display("FAIL ro_wr_reg got=%h exp=0", reg_q0[224 +: 32]); end
        apb_xfer(0, 0, 32'h101C, 0, 0, rd, er, lat);
        checks++; if (rd !== 32'h55 || er !== 0) begin errors++; $display("FAIL ro_rd got=%h/%b exp=00000055/0", rd, er); end
        apb_xfer(0, 0, 32'h1020, 0, 0, rd, er, lat);
        checks++; if (rd !== 0 || er !== 1) begin errors++; $display("FAIL oob_rd got=%h/%b exp=0/1", rd, er); end
        apb_xfer(0, 0, 32'h100A, 0, 0, rd, er, lat);
        checks++; if (rd !== 0 || er !== 1) begin errors++; $display("FAIL misalign_rd got=%h/%b exp=0/1", rd, er); end
        apb_xfer(0, 0, 32'h1002, 0, 0, rd, er, lat);
        checks++; if (rd !== 0 || er !== 1) begin errors++; $display("FAIL misalign2_rd got=%h/%b exp=0/1", rd, er); end
        apb_xfer(0, 0, 32'h0FFC, 0, 0, rd, er, lat);
        checks++; if (rd !== 0 || er !== 1) begin errors++; $display("FAIL below_base got=%h/%b exp=0/1", rd, er); end
        idle();
    endtask

    task automatic test_protocol();
        logic seen;
        seen = 0;
        @(posedge clk); #1;
        psel0 = 1; penable = 1; pwrite = 1; paddr = 32'h1000; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        repeat (4) begin @(posedge clk); #1; seen |= pready0; end
        idle();
        @(posedge clk); #1;
        checks++; if (seen !== 0) begin errors++; $display("FAIL penable_only_pready got=%b exp=0", seen); end
        checks++; if (reg_q0[0 +: 32] !== 0) begin errors++; $display("FAIL penable_only_reg got=%h exp=0", reg_q0[0 +: 32]); end
    endtask

    task automatic test_back_to_back();
        apb_xfer(1, 1, 32'h1004, 32'hA5A55A5A, 4'hF, rd, er, lat);
        checks++; if (lat !== 4 || er !== 0) begin errors++; $display("FAIL w3_wr lat/err got=%0d/%b exp=4/0", lat, er); end
        apb_xfer(1, 0, 32'h1004, 0, 0, rd, er, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL w3_rd_lat got=%0d exp=4", lat); end
        checks++; if (rd !== 32'hA5A55A5A) begin errors++; $display("FAIL w3_rd_data got=%h exp=a5a55a5a", rd); end
        apb_xfer(1, 1, 32'h1014, 32'h1234BEEF, 4'b0011, rd, er, lat);
        apb_xfer(1, 0, 32'h1014, 0, 0, rd, er, lat);
        checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL w3_strb_rd got=%h exp=0000beef", rd); end
        apb_xfer(1, 0, 32'h1020, 0, 0, rd, er, lat);
        checks++; if (er !== 1 || lat !== 4) begin errors++; $display("FAIL w3_err err/lat got=%b/%0d exp=1/4", er, lat); end
        idle();
    endtask

    task automatic test_abort_psel();
        logic seen;
        seen = 0;
        @(posedge clk); #1;
        psel3 = 1; penable = 0; pwrite = 1; paddr = 32'h1010; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        psel3 = 0; penable = 0;
        repeat (6) begin @(posedge clk); #1; seen |= pready3 | (|pulse3); end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_pready got=%b exp=0", seen); end
        checks++; if (reg_q3[128 +: 32] !== 0) begin errors++; $display("FAIL abort_reg got=%h exp=0", reg_q3[128 +: 32]); end
        apb_xfer(1, 0, 32'h1010, 0, 0, rd, er, lat);
        checks++; if (lat !== 4 || rd !== 0 || er !== 0) begin errors++; $display("FAIL abort_next got=%0d/%h/%b exp=4/0/0", lat, rd, er); end
        idle();
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        seen = 0;
        @(posedge clk); #1;
        psel3 = 1; penable = 0; pwrite = 1; paddr = 32'h1010; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; psel3 = 0; penable = 0;
        repeat (6) begin @(posedge clk); #1; seen |= pready3 | (|pulse3); end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstwait_pready got=%b exp=0", seen); end
        checks++; if (reg_q3[128 +: 32] !== 0) begin errors++; $display("FAIL rstwait_reg got=%h exp=0", reg_q3[128 +: 32]); end
        apb_xfer(1, 1, 32'h1010, 32'h11223344, 4'hF, rd, er, lat);
        checks++; if (lat !== 4 || er !== 0) begin errors++; $display("FAIL rstwait_wr got=%0d/%b exp=4/0", lat, er); end
        apb_xfer(1, 0, 32'h1010, 0, 0, rd, er, lat);
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL rstwait_rd got=%h exp=11223344", rd); end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp_rd;
        logic [3:0]  s;
        logic        w, exp_err;
        int          sel, idx;
        for (int i = 0; i < 8; i++) model[i] = '0;
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 10);
            if (sel < 8) a = 32'h1000 + 32'(4 * sel);
            else if (sel == 8) a = 32'h1020 + 32'(4 * $urandom_range(0, 3));
            else if (sel == 9) a = 32'h1000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
            else a = 32'h0FF0 + 32'(4 * $urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            idx = int'((a - 32'h1000) >> 2);
            exp_err = (a < 32'h1000) || (a >= 32'h1020) || (a[1:0] != 2'b00) || (w && idx == 7);
            exp_rd = (exp_err || w) ? 32'h0 : (idx == 7 ? 32'h55 : model[idx]);
            apb_xfer(0, w, a, d, s, rd, er, lat);
            checks++; if (er !== exp_err) begin errors++; $display("FAIL rnd_err t=%0d addr=%h got=%b exp=%b", t, a, er, exp_err); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL rnd_lat t=%0d got=%0d exp=1", t, lat); end
            if (!w) begin
                checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rd t=%0d addr=%h got=%h exp=%h", t, a, rd, exp_rd); end
            end
            if (w && !exp_err)
                for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            checks++; if (reg_q0[i*32 +: 32] !== model[i]) begin errors++; $display("FAIL rnd_reg_q[%0d] got=%h exp=%h", i, reg_q0[i*32 +: 32], model[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 7; i++) hw_in[i*32 +: 32] = 32'hA0A00000 + 32'(i);
        hw_in[224 +: 32] = 32'h55;
        test_reset();
        test_write_strobe();
        test_errors();
        test_protocol();
        test_back_to_back();
        test_abort_psel();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
